// File: rtl/sseg_pkg.sv
// Shared constants and nibble decode table for the seven-segment scan driver.
// All segment patterns are active-low, ordered g..a.
package sseg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Nibble F shows "H" rather than "F" on this board.
  function automatic logic [6:0] hexPattern(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'h0: pat = 7'b1000000;
      4'h1: pat = 7'b1111001;
      4'h2: pat = 7'b0100100;
      4'h3: pat = 7'b0110000;
      4'h4: pat = 7'b0011001;
      4'h5: pat = 7'b0010010;
      4'h6: pat = 7'b0000010;
      4'h7: pat = 7'b1111000;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0010000;
      4'hA: pat = 7'b0001000;
      4'hB: pat = 7'b0000011;
      4'hC: pat = 7'b1000110;
      4'hD: pat = 7'b0100001;
      4'hE: pat = 7'b0000110;
      default: pat = 7'b0001001;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sseg_scan_driver_dec.sv
// Nibble-to-segment decoder; passes the dp request through still active-high.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] hex_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {dp_i, hexPattern(hex_i)};

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit common-anode display driver with frame-level
// double buffering, blanking, leading-zero suppression and PWM brightness.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int PRESC_W  = 16,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            sseg,
  output logic                  frame_tick
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [PRESC_W-1:0]    presc_q;
  logic [IDX_W-1:0]      idx_q;
  logic [4*N_DIGITS-1:0] hex_q;
  logic [N_DIGITS-1:0]   dp_q, blank_q;
  logic                  lz_q;
  logic [BRIGHT_W-1:0]   bright_q;
  logic                  loaded_q, tick_q;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;

  logic                  slotEnd, frameEnd, isLit;
  logic [N_DIGITS-1:0]   upperZero, lzMask, anSel;
  logic [3:0]            selNibble;
  logic                  selDp, selBlank, selLz;
  logic [7:0]            decSeg;

  assign slotEnd  = &presc_q;
  assign frameEnd = slotEnd && (idx_q == LAST_IDX);
  assign isLit    = (&bright_q) || (presc_q[PRESC_W-1 -: BRIGHT_W] < bright_q);

  // Prefix-AND from the top digit down: a digit is suppressible only if it
  // and every more significant nibble are zero. Digit 0 is always shown.
  always_comb begin
    upperZero = '0;
    lzMask    = '0;
    upperZero[N_DIGITS-1] = (hex_q[4*N_DIGITS-4 +: 4] == 4'h0);
    for (int i = N_DIGITS - 2; i >= 0; i--)
      upperZero[i] = upperZero[i+1] && (hex_q[4*i +: 4] == 4'h0);
    for (int i = 1; i < N_DIGITS; i++)
      lzMask[i] = lz_q && upperZero[i];
  end

  always_comb begin
    selNibble = 4'h0;
    selDp     = 1'b0;
    selBlank  = 1'b0;
    selLz     = 1'b0;
    anSel     = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        selNibble = hex_q[4*i +: 4];
        selDp     = dp_q[i];
        selBlank  = blank_q[i];
        selLz     = lzMask[i];
        anSel[i]  = 1'b0;
      end
    end
  end

  hex_to_sseg u_dec (
    .hex_i (selNibble),
    .dp_i  (selDp),
    .seg_o (decSeg)
  );

  // An LZ-suppressed digit keeps its dp; blanking and PWM-off darken everything.
  always_comb begin
    an_d   = AN_OFF[N_DIGITS-1:0];
    sseg_d = SEG_OFF;
    if (isLit && !selBlank) begin
      an_d   = anSel;
      sseg_d = selLz ? {~decSeg[7], 7'h7F} : {~decSeg[7], decSeg[6:0]};
    end
  end

  // loaded_q delays the tick so it coincides with the first output cycle
  // driven by the freshly loaded shadows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      hex_q    <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      lz_q     <= 1'b0;
      bright_q <= '0;
      loaded_q <= 1'b0;
      tick_q   <= 1'b0;
      an_q     <= AN_OFF[N_DIGITS-1:0];
      sseg_q   <= SEG_OFF;
    end else begin
      presc_q  <= presc_q + 1'b1;
      if (slotEnd)
        idx_q <= frameEnd ? '0 : idx_q + 1'b1;
      if (frameEnd) begin
        hex_q    <= hex_in;
        dp_q     <= dp_in;
        blank_q  <= blank_in;
        lz_q     <= lz_en;
        bright_q <= bright;
      end
      loaded_q <= frameEnd;
      tick_q   <= loaded_q;
      an_q     <= an_d;
      sseg_q   <= sseg_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomized and directed bench for sseg_scan_driver (4-digit and 3-digit
// instances) against a frame-position reference model.
module tb_sseg_scan_driver;
  import sseg_pkg::*;

  localparam int SLOT   = 16;
  localparam int FRAME4 = 4 * SLOT;
  localparam int FRAME3 = 3 * SLOT;

  typedef struct {
    logic [31:0] hex;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic        lz;
    logic [1:0]  br;
  } snap_t;

  logic        clk, reset;
  logic [15:0] hexIn;
  logic [3:0]  dpIn, blankIn;
  logic        lzIn;
  logic [1:0]  brightIn;
  logic [3:0]  an4;
  logic [7:0]  sseg4;
  logic        tick4;
  logic [2:0]  an3;
  logic [7:0]  sseg3;
  logic        tick3;

  int    testsRun, testsFailed, edgeCount;
  snap_t s4, s3;

  sseg_scan_driver #(.N_DIGITS(4), .PRESC_W(4), .BRIGHT_W(2)) dut4 (
    .clk(clk), .reset(reset), .hex_in(hexIn), .dp_in(dpIn), .blank_in(blankIn),
    .lz_en(lzIn), .bright(brightIn), .an(an4), .sseg(sseg4), .frame_tick(tick4)
  );

  sseg_scan_driver #(.N_DIGITS(3), .PRESC_W(4), .BRIGHT_W(2)) dut3 (
    .clk(clk), .reset(reset), .hex_in(hexIn[11:0]), .dp_in(dpIn[2:0]),
    .blank_in(blankIn[2:0]), .lz_en(lzIn), .bright(brightIn), .an(an3),
    .sseg(sseg3), .frame_tick(tick3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an, sseg} for a given position within the frame.
  function automatic logic [15:0] refOut(input int pos, input snap_t s);
    int d = pos / SLOT;
    int pr = pos % SLOT;
    logic [7:0] anE = 8'hFF;
    logic [7:0] segE = 8'hFF;
    logic isLit = (s.br == 2'd3) || ((pr / 4) < int'(s.br));
    if (isLit && !s.blank[d]) begin
      anE[d] = 1'b0;
      if (s.lz && d >= 1 && (s.hex >> (4 * d)) == 32'd0)
        segE = {~s.dp[d], 7'h7F};
      else
        segE = {~s.dp[d], hexPattern(s.hex[4*d +: 4])};
    end
    return {anE, segE};
  endfunction

  function automatic snap_t capture(input int n);
    snap_t s;
    s.hex   = (n == 3) ? {20'h0, hexIn[11:0]} : {16'h0, hexIn};
    s.dp    = (n == 3) ? {5'h0, dpIn[2:0]} : {4'h0, dpIn};
    s.blank = (n == 3) ? {5'h0, blankIn[2:0]} : {4'h0, blankIn};
    s.lz    = lzIn;
    s.br    = brightIn;
    return s;
  endfunction

  function automatic snap_t zeroSnap();
    snap_t s;
    s.hex = '0; s.dp = '0; s.blank = '0; s.lz = 1'b0; s.br = '0;
    return s;
  endfunction

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h at edge %0d", tag, obs, exp, edgeCount);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] h, input logic [3:0] d,
                               input logic [3:0] b, input logic l, input logic [1:0] br);
    hexIn = h; dpIn = d; blankIn = b; lzIn = l; brightIn = br;
  endtask

  // One clock: predict from pre-edge model state, capture shadows at frame ends, compare.
  task automatic checkOutput();
    logic [15:0] e4, e3;
    logic expT4, expT3;
    @(posedge clk);
    edgeCount++;
    e4 = refOut((edgeCount - 1) % FRAME4, s4);
    e3 = refOut((edgeCount - 1) % FRAME3, s3);
    expT4 = (edgeCount >= FRAME4 + 1) && ((edgeCount - 1) % FRAME4 == 0);
    expT3 = (edgeCount >= FRAME3 + 1) && ((edgeCount - 1) % FRAME3 == 0);
    if (edgeCount % FRAME4 == 0) s4 = capture(4);
    if (edgeCount % FRAME3 == 0) s3 = capture(3);
    #1;
    checkVal("an4",   16'(an4),   16'(e4[11:8]));
    checkVal("sseg4", 16'(sseg4), 16'(e4[7:0]));
    checkVal("tick4", 16'(tick4), 16'(expT4));
    checkVal("an3",   16'(an3),   16'(e3[10:8]));
    checkVal("sseg3", 16'(sseg3), 16'(e3[7:0]));
    checkVal("tick3", 16'(tick3), 16'(expT3));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) checkOutput();
  endtask

  task automatic checkDark(input string tag);
    checkVal({tag, "_an4"},   16'(an4),   16'h000F);
    checkVal({tag, "_sseg4"}, 16'(sseg4), 16'h00FF);
    checkVal({tag, "_tick4"}, 16'(tick4), 16'h0000);
    checkVal({tag, "_an3"},   16'(an3),   16'h0007);
  endtask

  initial begin
    testsRun = 0; testsFailed = 0; edgeCount = 0;
    s4 = zeroSnap(); s3 = zeroSnap();
    applyStimulus(16'h0000, 4'h0, 4'h0, 1'b0, 2'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkDark("reset");
    reset = 1'b0;

    applyStimulus(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
    runCycles(2 * FRAME4);
    applyStimulus(16'h0040, 4'b1000, 4'h0, 1'b1, 2'd3);
    runCycles(FRAME4 + 20);
    applyStimulus(16'h0040, 4'b1000, 4'h0, 1'b0, 2'd3);
    runCycles(FRAME4);
    applyStimulus(16'h1234, 4'b0010, 4'b0010, 1'b0, 2'd3);
    runCycles(FRAME4);
    applyStimulus(16'h5678, 4'h0, 4'h0, 1'b0, 2'd1);
    runCycles(FRAME4);
    applyStimulus(16'h9ABC, 4'hF, 4'h0, 1'b0, 2'd0);
    runCycles(FRAME4);
    applyStimulus(16'h0000, 4'b0001, 4'h0, 1'b1, 2'd2);
    runCycles(FRAME4);

    for (int k = 0; k < 12; k++) begin
      applyStimulus(16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                    1'($urandom), 2'($urandom));
      if (k % 3 == 0) hexIn = hexIn & 16'h00FF;
      runCycles($urandom_range(1, 100));
    end

    // Asynchronous reset landing between clock edges.
    applyStimulus(16'hFEDC, 4'h0, 4'h0, 1'b0, 2'd3);
    runCycles(37);
    #2;
    reset = 1'b1;
    #1;
    checkDark("midreset");
    @(posedge clk);
    #1;
    checkDark("heldreset");
    reset = 1'b0;
    edgeCount = 0;
    s4 = zeroSnap(); s3 = zeroSnap();
    applyStimulus(16'h12AF, 4'b0100, 4'h0, 1'b0, 2'd3);
    runCycles(2 * FRAME4 + 8);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
